// File: rtl/pkt_rr_arbiter.sv
// Packet-level round-robin arbiter merging NUM_PORTS AXI-Stream inputs onto one output.
// Optional per-port packet counters on output pkt_cnt when PKT_ARB_STATS_EN is defined.
module pkt_rr_arbiter #(
  parameter int unsigned NUM_PORTS            = 4,
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128
) (
  input  logic                                           CLK_156,
  input  logic                                           ARESET_156,
  input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tkeep,
  input  logic [NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
  input  logic [NUM_PORTS-1:0]                           s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]                           s_axis_tlast,
  output logic [NUM_PORTS-1:0]                           s_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]                 m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]               m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]                m_axis_tuser,
  output logic                                           m_axis_tvalid,
  output logic                                           m_axis_tlast,
  input  logic                                           m_axis_tready
`ifdef PKT_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*32-1:0]                        pkt_cnt
`endif
);

  localparam int unsigned KeepW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int unsigned IdxW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {StArb, StFwd} state_e;

  state_e          state_q;
  logic [IdxW-1:0] grant_q;
  logic [IdxW-1:0] rr_ptr_q;
  logic [IdxW-1:0] pick_idx;
  logic [IdxW-1:0] scan_sel;
  logic [IdxW-1:0] next_ptr;
  logic            any_valid;
  logic            pkt_done;
  int unsigned     scan_idx;

  // First requesting port at or above rr_ptr, wrapping past NUM_PORTS-1.
  always_comb begin
    pick_idx  = rr_ptr_q;
    any_valid = 1'b0;
    scan_idx  = 0;
    scan_sel  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      scan_idx = {{(32-IdxW){1'b0}}, rr_ptr_q} + i;
      if (scan_idx >= NUM_PORTS) begin
        scan_idx = scan_idx - NUM_PORTS;
      end
      scan_sel = scan_idx[IdxW-1:0];
      if (!any_valid && s_axis_tvalid[scan_sel]) begin
        pick_idx  = scan_sel;
        any_valid = 1'b1;
      end
    end
  end

  assign pkt_done = (state_q == StFwd) && s_axis_tvalid[grant_q] && s_axis_tlast[grant_q] &&
                    m_axis_tready;
  assign next_ptr = (grant_q == IdxW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;

  always_ff @(posedge CLK_156 or posedge ARESET_156) begin
    if (ARESET_156) begin
      state_q  <= StArb;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      case (state_q)
        StArb: begin
          if (any_valid) begin
            grant_q <= pick_idx;
            state_q <= StFwd;
          end
        end
        StFwd: begin
          // Grant survives tvalid gaps; only the tlast transfer releases it.
          if (pkt_done) begin
            rr_ptr_q <= next_ptr;
            state_q  <= StArb;
          end
        end
        default: state_q <= StArb;
      endcase
    end
  end

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tuser  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (state_q == StFwd) begin
      m_axis_tdata           = s_axis_tdata[grant_q*C_S_AXIS_DATA_WIDTH +: C_S_AXIS_DATA_WIDTH];
      m_axis_tkeep           = s_axis_tkeep[grant_q*KeepW +: KeepW];
      m_axis_tuser           = s_axis_tuser[grant_q*C_S_AXIS_TUSER_WIDTH +: C_S_AXIS_TUSER_WIDTH];
      m_axis_tvalid          = s_axis_tvalid[grant_q];
      m_axis_tlast           = s_axis_tlast[grant_q];
      s_axis_tready[grant_q] = m_axis_tready;
    end
  end

`ifdef PKT_ARB_STATS_EN
  logic [NUM_PORTS-1:0][31:0] cnt_q;

  always_ff @(posedge CLK_156 or posedge ARESET_156) begin
    if (ARESET_156) begin
      cnt_q <= '0;
    end else if (pkt_done) begin
      cnt_q[grant_q] <= cnt_q[grant_q] + 32'd1;
    end
  end

  assign pkt_cnt = cnt_q;
`endif

endmodule

// File: doc/pkt_rr_arbiter.md
PKT_RR_ARBITER -- requirements
Module: pkt_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of AXI-Stream input ports; legal range 2..8.
REQ-002 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 256: tdata width; tkeep width is C_S_AXIS_DATA_WIDTH/8.
REQ-003 SHALL have parameter C_S_AXIS_TUSER_WIDTH, default 128: tuser width.
REQ-004 SHALL have port CLK_156, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port ARESET_156, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port s_axis_tdata, input, NUM_PORTS*C_S_AXIS_DATA_WIDTH bits: packed per-port data, port i at slice i.
REQ-007 SHALL have port s_axis_tkeep, input, NUM_PORTS*C_S_AXIS_DATA_WIDTH/8 bits: packed per-port byte enables.
REQ-008 SHALL have port s_axis_tuser, input, NUM_PORTS*C_S_AXIS_TUSER_WIDTH bits: packed per-port metadata.
REQ-009 SHALL have ports s_axis_tvalid, s_axis_tlast (input) and s_axis_tready (output), NUM_PORTS bits each: per-port handshake, bit i for port i.
REQ-010 SHALL have ports m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast (output) and m_axis_tready (input): merged stream towards the packet processor, widths as for one input port.

Function
REQ-011 SHALL implement a two-state FSM: ARB and FWD.
REQ-012 ARB: if any s_axis_tvalid bit is set, SHALL register grant to the first valid port found searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., NUM_PORTS-1, 0, ...) and go to FWD on the next edge; otherwise SHALL stay in ARB.
REQ-013 ARB: SHALL drive m_axis_tvalid=0, m_axis_tdata/tkeep/tuser/tlast=0 and all s_axis_tready bits 0.
REQ-014 FWD: SHALL combinationally route the granted port's tdata/tkeep/tuser/tlast/tvalid to m_axis_*.
REQ-015 FWD: s_axis_tready[grant] SHALL equal m_axis_tready; every other s_axis_tready bit SHALL be 0.
REQ-016 Grant SHALL be held for the whole packet, until a beat with tvalid & tready & tlast transfers on the granted port; the granted port deasserting tvalid mid-packet SHALL NOT release the grant.
REQ-017 On the tlast transfer, rr_ptr SHALL load (grant+1) mod NUM_PORTS and the FSM SHALL return to ARB.
REQ-018 Arbitration latency SHALL be 1 cycle from tvalid seen in ARB to the first beat being presentable in FWD.
REQ-019 There SHALL be exactly one idle (ARB) cycle between consecutive packets, even when requests are back-to-back.
REQ-020 A single-beat packet (tlast on the first beat) SHALL be forwarded and SHALL release the grant in the same cycle.
REQ-021 With m_axis_tready=0 in FWD, output data SHALL be held by the granted source (AXIS rules) and no state SHALL change.
REQ-022 Requests arriving on non-granted ports during FWD SHALL wait (tready=0) and SHALL be served per REQ-012 at the next ARB.
REQ-023 Beat contents SHALL be passed unmodified; packets SHALL never interleave on m_axis.

Reset
REQ-024 ARESET_156 high SHALL immediately force state=ARB, grant=0, rr_ptr=0, all s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tkeep/tuser=0.
REQ-025 Reset asserted mid-packet SHALL abandon the packet; after release, arbitration SHALL restart from port 0 with no memory of the truncated packet.

Configuration
REQ-026 Macro PKT_ARB_STATS_EN, when defined, SHALL add output pkt_cnt (NUM_PORTS*32 bits): per-port 32-bit counters, incremented on each tlast transfer from that port, wrapping 0xFFFFFFFF->0, reset to 0.
REQ-027 Without PKT_ARB_STATS_EN, port pkt_cnt and its counters SHALL NOT exist; all other behaviour SHALL be identical.

Verification
REQ-028 Single port: port 2 sends a 3-beat packet, m_axis_tready=1 -> m_axis shows 3 beats starting 1 cycle after tvalid, identical tdata/tkeep/tuser; rr_ptr becomes 3.
REQ-029 Fairness: all 4 ports continuously valid with 2-beat packets -> grant order 0,1,2,3,0; one ARB cycle between packets.
REQ-030 Backpressure: m_axis_tready toggles 1,0,1,0 during a 4-beat packet from port 1 -> exactly 4 transfers, no duplicated or dropped beat, tready[1] mirrors m_axis_tready.
REQ-031 Hold grant: port 0 drops tvalid for 5 cycles mid-packet while port 3 is valid -> s_axis_tready[3] stays 0 until port 0's tlast transfers.
REQ-032 Reset mid-packet: assert ARESET_156 on beat 2 of 4 from port 2 -> m_axis_tvalid=0 immediately; after release with ports 1 and 3 valid, port 1 is granted first.
REQ-033 With PKT_ARB_STATS_EN: 3 packets from port 0 and 1 from port 3 -> pkt_cnt slices read 3,0,0,1; preloaded 0xFFFFFFFF wraps to 0.
